// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: edge-captures IR frames, filters held-key repeats, queues commands for a valid/ready consumer
module ir_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 2_500_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [11:0]                  rx_data,
  input  logic                         rx_rdy,
  output logic [11:0]                  cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         rpt_drop,
  output logic [7:0]                   drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF + 1) : 1;
  logic          rx_q, cap_vld, last_vld;
  logic [11:0]   cap_data, last_data;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [11:0]   mem [DEPTH];
  logic          rpt, full, wr, rd;
  // commit decision and handshake, all from cycle-start registered state
  always_comb begin
    rpt       = last_vld && cap_data == last_data && hold_cnt != '0 && HOLDOFF != 0;
    full      = fifo_level == LW'(DEPTH);
    wr        = cap_vld && !rpt && !full;
    cmd_valid = fifo_level != '0;
    rd        = cmd_valid && cmd_ready;
    cmd_data  = cmd_valid ? mem[rd_ptr] : 12'h000;
  end
  // capture, repeat filter, drop accounting and queue pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= 1'b1;
      cap_vld    <= 1'b0;
      cap_data   <= '0;
      last_vld   <= 1'b0;
      last_data  <= '0;
      hold_cnt   <= '0;
      rpt_drop   <= 1'b0;
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      rx_q     <= rx_rdy;
      cap_vld  <= rx_rdy && !rx_q;
      if (rx_rdy && !rx_q) cap_data <= rx_data;
      rpt_drop <= cap_vld && rpt;
      if (cap_vld && !rpt && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (cap_vld && !rpt) begin
        last_data <= cap_data;
        last_vld  <= 1'b1;
      end
      hold_cnt   <= cap_vld ? HW'(HOLDOFF) : hold_cnt - HW'(hold_cnt != '0);
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= fifo_level + LW'(wr) - LW'(rd);
    end
  end
  // queue storage; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= cap_data;
  end
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb_ir_cmd_scheduler: scoreboard bench for ir_cmd_scheduler
module tb_ir_cmd_scheduler;
  logic        clk = 0, rst_n = 0, rx_rdy = 1, cmd_ready = 0;
  logic [11:0] rx_data = '0, cmd_data;
  logic        cmd_valid, rpt_drop;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;
  int          checks = 0, errors = 0;
  logic [11:0] exp_q [$];

  ir_cmd_scheduler #(.DEPTH(4), .HOLDOFF(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fifo_level(fifo_level), .rpt_drop(rpt_drop), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns at the negedge after the commit edge
  task automatic frame(input logic [11:0] d, input bit acc);
    if (acc) exp_q.push_back(d);
    rx_data = d;
    rx_rdy  = 1;
    @(negedge clk);
    rx_rdy = 0;
    @(negedge clk);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_data"}, cmd_data, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_rpt"}, rpt_drop, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  // pops the scoreboard whenever the next edge will accept the head
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", cmd_data, 12'hFFF);
      else check("pop_data", cmd_data, exp_q.pop_front());
    end
  end

  initial begin
    idle(3);
    reset_vals("rst");
    rst_n = 1;
    idle(10);
    check("held_level", fifo_level, 0);
    check("held_valid", cmd_valid, 0);
    rx_rdy = 0;
    idle(3);
    cmd_ready = 1;
    exp_q.push_back(12'h0A5);
    rx_data = 12'h0A5;
    rx_rdy  = 1;
    @(negedge clk);
    rx_rdy = 0;
    check("lat_k", cmd_valid, 0);
    @(negedge clk);
    check("lat_valid", cmd_valid, 1);
    check("lat_rpt", rpt_drop, 0);
    @(negedge clk);
    check("lat_popped", cmd_valid, 0);
    idle(7);
    frame(12'h0A5, 0);
    check("rpt10_pulse", rpt_drop, 1);
    check("rpt10_level", fifo_level, 0);
    @(negedge clk);
    check("rpt10_once", rpt_drop, 0);
    idle(17);
    frame(12'h0A5, 0);
    check("rpt20_pulse", rpt_drop, 1);
    idle(19);
    frame(12'h0A5, 1);
    check("rpt21_norpt", rpt_drop, 0);
    idle(25);
    frame(12'h0A5, 1);
    check("seq1_rpt", rpt_drop, 0);
    idle(3);
    frame(12'h0A6, 1);
    check("seq2_rpt", rpt_drop, 0);
    idle(3);
    cmd_ready = 0;
    for (int i = 1; i <= 6; i++) frame(12'h100 + 12'(i), i <= 4);
    check("full_level", fifo_level, 4);
    check("full_drop", drop_cnt, 2);
    cmd_ready = 1;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      check("drain_level", fifo_level, i);
    end
    check("drain_valid", cmd_valid, 0);
    check("drain_data", cmd_data, 0);
    cmd_ready = 0;
    for (int i = 1; i <= 4; i++) frame(12'h200 + 12'(i), 1);
    rx_data = 12'h205;
    rx_rdy  = 1;
    @(negedge clk);
    rx_rdy    = 0;
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    check("race_level", fifo_level, 3);
    check("race_drop", drop_cnt, 3);
    cmd_ready = 1;
    idle(4);
    check("race_drain", fifo_level, 0);
    cmd_ready = 0;
    for (int i = 1; i <= 4; i++) frame(12'h300 + 12'(i), 1);
    for (int i = 0; i < 300; i++) frame(12'h400 + 12'(i), 0);
    check("sat_drop", drop_cnt, 255);
    check("sat_level", fifo_level, 4);
    rx_data = 12'h777;
    rx_rdy  = 1;
    @(negedge clk);
    rx_rdy = 0;
    rst_n  = 0;
    exp_q.delete();
    #1;
    reset_vals("midrst");
    idle(2);
    rst_n = 1;
    idle(2);
    reset_vals("post");
    cmd_ready = 1;
    frame(12'h555, 1);
    idle(3);
    check("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_cmd_scheduler.md
# ir_cmd_scheduler

Buffers and paces decoded IR commands between the IR receiver and its consumers (LED manager, command display). Detects each new frame from the receiver's level-style ready, suppresses auto-repeat frames of a held key inside a hold-off window, queues surviving commands in a small FIFO, and offers them downstream with a valid/ready handshake. This replaces the bare capture register and `new_cmd` pulse in the top level, so no command is lost while a consumer is busy.

## Interface

- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLDOFF, 2_500_000: repeat hold-off in clk cycles (50 ms at 50 MHz); 0 disables filtering.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  12  decoded frame from receiver; stable while rx_rdy high.
- rx_rdy  in  1  receiver ready level; a 0→1 transition marks one new frame.
- cmd_data  out  12  head-of-queue command; 12'h000 when cmd_valid=0.
- cmd_valid  out  1  queue non-empty.
- cmd_ready  in  1  consumer accepts head when high with cmd_valid.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.
- rpt_drop  out  1  one-cycle pulse: frame suppressed as repeat.
- drop_cnt  out  8  saturating count of frames lost to FIFO full.

## Operation

- Edge detect: rx_q <= rx_rdy each cycle; event when rx_rdy=1 && rx_q=0. rx_q resets to 1, so a level already high at reset release is not captured.
- Stage CAPTURE (event cycle): cap_data <= rx_data, cap_vld <= 1.
- Stage COMMIT (next cycle, cap_vld=1), in priority:
  - repeat = last_vld && cap_data==last_data && hold_cnt!=0 && HOLDOFF!=0.
  - repeat: no write; rpt_drop=1; hold_cnt <= HOLDOFF (held key stays suppressed).
  - else FIFO full: no write; drop_cnt += 1 (saturate at 255); last_data <= cap_data, last_vld <= 1, hold_cnt <= HOLDOFF.
  - else: write cap_data at tail; last_data/last_vld/hold_cnt updated as above.
  - cap_vld <= 0.
- hold_cnt: decrements by 1 each cycle when non-zero and not loaded; load wins over decrement.
- Comparison uses all 12 bits; any differing bit is a new command.
- FIFO: first-word-fall-through, circular read/write pointers wrap modulo DEPTH. Pop when cmd_valid && cmd_ready.
- Full/empty evaluated on the registered level at cycle start: a write on a full FIFO is rejected even if a pop occurs the same cycle; a pop on empty is ignored. Write and pop together on a non-full, non-empty FIFO leave the level unchanged.
- Reset (any time, including mid-COMMIT): FIFO emptied, pointers 0, cap_vld=0, last_vld=0, hold_cnt=0, drop_cnt=0, rx_q=1. Contents discarded.

## Timing

- Reset values: cmd_valid=0, cmd_data=12'h000, fifo_level=0, rpt_drop=0, drop_cnt=0.
- Latency: rx_rdy first sampled high at edge k → FIFO write at edge k+1 → cmd_valid=1 and cmd_data valid after edge k+1 (empty queue).
- rpt_drop asserted for exactly the cycle after edge k+1; drop_cnt/fifo_level update at edge k+1.
- Pop at edge p: next entry (or 12'h000 with cmd_valid=0) visible after edge p; fifo_level decrements at edge p.
- Minimum event spacing is 2 cycles (rx_rdy must fall). Events never overlap COMMIT.
- Hold-off window: repeat suppressed if it commits ≤ HOLDOFF cycles after the previous commit load.

## Test plan

- Reset with rx_rdy=1 held, release, hold 10 cycles → no write, fifo_level=0, cmd_valid=0.
- HOLDOFF=20, cmd_ready=1; frame 12'h0A5 → cmd_valid=1 with 12'h0A5 two edges after rx_rdy rise, popped next edge; same frame 10 cycles later → rpt_drop pulse, no write; again 30 cycles after that → accepted.
- HOLDOFF=20; 12'h0A5 then 12'h0A6 5 cycles later → both queued in order, no rpt_drop.
- DEPTH=4, cmd_ready=0; 6 distinct frames → fifo_level=4, drop_cnt=2; then cmd_ready=1 → four first frames out in order, one per cycle, then cmd_valid=0.
- Full FIFO, event commits on the same edge as a pop → write rejected, drop_cnt+1, fifo_level=3.
- 300 frames into full FIFO → drop_cnt saturates at 255; rst_n pulse mid-COMMIT → all outputs return to reset values.
